// File: rtl/sd_spi_card_responder.sv
// ---------------------------------------------------------------------------
// sd_spi_card_responder
//
// Behavioural SD card target in SPI mode 0, clocked entirely in the system
// clock domain. The host pins are synchronised and edge-detected. Command
// frames (48 bits, CRC ignored) are decoded and answered with R1, R7 or R3
// responses. CMD17 returns one 512-byte block fetched from a byte-wide
// memory port.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   sd_sclk      SPI clock from the host (asynchronous, period >= 8 clk)
//   sd_cs_n      chip select, active low
//   sd_mosi      host -> card serial data
//   sd_miso      card -> host serial data, changes after sclk falling edges
//   mem_rd       one-clk read strobe for mem_addr
//   mem_addr     byte address of the block byte being fetched
//   mem_rdata    read data, valid the clk after mem_rd
//   cmd_valid    one-clk pulse when a command frame has been received
//   cmd_index    index of the last command
//   cmd_arg      argument of the last command
//   card_ready   set once ACMD41 has reported the card ready
// ---------------------------------------------------------------------------
module sd_spi_card_responder #(
  parameter int ADDR_W         = 24,
  parameter int NCR_BYTES      = 1,
  parameter int READ_GAP_BYTES = 2,
  parameter int ACMD41_BUSY    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sd_sclk,
  input  logic              sd_cs_n,
  input  logic              sd_mosi,
  output logic              sd_miso,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              cmd_valid,
  output logic [5:0]        cmd_index,
  output logic [31:0]       cmd_arg,
  output logic              card_ready
);

  typedef enum logic [2:0] {
    ST_RX    = 3'd0,
    ST_GAP   = 3'd1,
    ST_RESP  = 3'd2,
    ST_RGAP  = 3'd3,
    ST_TOKEN = 3'd4,
    ST_DATA  = 3'd5,
    ST_CRC   = 3'd6
  } state_t;

  localparam logic [8:0] NCR_LAST_C  = 9'(NCR_BYTES - 1);
  localparam logic [8:0] RGAP_LAST_C = 9'(READ_GAP_BYTES - 1);
  localparam logic [8:0] DATA_LAST_C = 9'd511;
  localparam logic [7:0] ACMD_BUSY_C = 8'(ACMD41_BUSY);

  // synchronisers and edge detection
  logic [1:0] sclk_sync_r;
  logic [1:0] cs_sync_r;
  logic [1:0] mosi_sync_r;
  logic       sclk_prev_r;
  logic       sclk_rise_s;
  logic       sclk_fall_s;
  logic       cs_high_s;
  logic       rx_bit_s;

  // receive path
  logic [44:0] rx_sr_r;
  logic [5:0]  rx_cnt_r;
  logic        rx_step_s;
  logic        frame_done_s;
  logic [5:0]  idx_s;
  logic [31:0] arg_s;

  // sequencer
  state_t     state_r;
  state_t     state_nxt_s;
  logic [8:0] byte_cnt_r;
  logic [8:0] byte_cnt_nxt_s;
  logic [2:0] tx_bit_r;
  logic [6:0] tx_shift_r;
  logic       miso_r;
  logic       tx_step_s;
  logic       byte_start_s;
  logic       byte_end_s;
  logic [7:0] cur_byte_s;

  // response and card status
  logic [39:0] resp_r;
  logic [2:0]  resp_last_r;
  logic        do_read_r;
  logic        idle_r;
  logic        ready_r;
  logic [7:0]  acmd_cnt_r;
  logic        app_r;
  logic        cmd_valid_r;
  logic [5:0]  cmd_index_r;
  logic [31:0] cmd_arg_r;

  // decode results for the frame completing this clk
  logic        idle_nxt_s;
  logic        ready_nxt_s;
  logic [7:0]  acmd_nxt_s;
  logic        app_nxt_s;
  logic        illegal_s;
  logic        read_nxt_s;
  logic [2:0]  resp_last_nxt_s;
  logic [31:0] resp_tail_s;
  logic [7:0]  r1_s;

  // memory port
  logic              mem_rd_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              rd_dly_r;
  logic [7:0]        hold_r;
  logic [ADDR_W-1:0] base_s;

  assign sclk_rise_s  = sclk_sync_r[1] & ~sclk_prev_r;
  assign sclk_fall_s  = ~sclk_sync_r[1] & sclk_prev_r;
  assign cs_high_s    = cs_sync_r[1];
  assign rx_bit_s     = mosi_sync_r[1];
  assign rx_step_s    = sclk_rise_s & ~cs_high_s & (state_r == ST_RX);
  assign frame_done_s = rx_step_s & (rx_cnt_r == 6'd47);
  assign tx_step_s    = sclk_fall_s & ~cs_high_s & (state_r != ST_RX);
  assign byte_start_s = tx_step_s & (tx_bit_r == 3'd7);
  assign byte_end_s   = tx_step_s & (tx_bit_r == 3'd0);

  // Frame bit k sits in rx_sr_r[k-1] before the final bit is shifted in.
  assign idx_s = rx_sr_r[44:39];
  assign arg_s = rx_sr_r[38:7];

  // Block number times 512 at full width, truncated to the port width.
  assign base_s = ADDR_W'({cmd_arg_r, 9'd0});

  // Two-stage synchronisers for the host pins plus the sclk edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= 2'b00;
      cs_sync_r   <= 2'b11;
      mosi_sync_r <= 2'b11;
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], sd_sclk};
      cs_sync_r   <= {cs_sync_r[0], sd_cs_n};
      mosi_sync_r <= {mosi_sync_r[0], sd_mosi};
      sclk_prev_r <= sclk_sync_r[1];
    end
  end

  // Command shift register and frame bit counter. A frame begins at a 0
  // followed by a 1; a repeated 0 keeps the counter waiting for the 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr_r  <= '1;
      rx_cnt_r <= 6'd0;
    end else if (cs_high_s) begin
      rx_cnt_r <= 6'd0;
    end else if (rx_step_s) begin
      rx_sr_r <= {rx_sr_r[43:0], rx_bit_s};
      if (rx_cnt_r == 6'd0) begin
        rx_cnt_r <= rx_bit_s ? 6'd0 : 6'd1;
      end else if (rx_cnt_r == 6'd1) begin
        rx_cnt_r <= rx_bit_s ? 6'd2 : 6'd1;
      end else if (rx_cnt_r == 6'd47) begin
        rx_cnt_r <= 6'd0;
      end else begin
        rx_cnt_r <= rx_cnt_r + 6'd1;
      end
    end
  end

  // Command decode: new card status and response bytes for the frame.
  always_comb begin
    idle_nxt_s      = idle_r;
    ready_nxt_s     = ready_r;
    acmd_nxt_s      = acmd_cnt_r;
    app_nxt_s       = 1'b0;
    illegal_s       = 1'b0;
    read_nxt_s      = 1'b0;
    resp_last_nxt_s = 3'd0;
    resp_tail_s     = 32'h0000_0000;
    case (idx_s)
      6'd0: begin
        idle_nxt_s  = 1'b1;
        ready_nxt_s = 1'b0;
        acmd_nxt_s  = 8'd0;
      end
      6'd8: begin
        resp_last_nxt_s = 3'd4;
        resp_tail_s     = {20'h0_0000, arg_s[11:8], arg_s[7:0]};
      end
      6'd16: begin
        illegal_s = 1'b0;
      end
      6'd17: begin
        if (ready_r) begin
          read_nxt_s = 1'b1;
        end else begin
          illegal_s = 1'b1;
        end
      end
      6'd41: begin
        if (!app_r) begin
          illegal_s = 1'b1;
        end else if (acmd_cnt_r < ACMD_BUSY_C) begin
          acmd_nxt_s = acmd_cnt_r + 8'd1;
        end else begin
          idle_nxt_s  = 1'b0;
          ready_nxt_s = 1'b1;
        end
      end
      6'd55: begin
        app_nxt_s = 1'b1;
      end
      6'd58: begin
        resp_last_nxt_s = 3'd4;
        resp_tail_s     = 32'hC0FF_8000;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
    r1_s = {5'b00000, illegal_s, 1'b0, idle_nxt_s};
  end

  // Latch the command, its response and the updated card status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_r <= 1'b0;
      cmd_index_r <= 6'd0;
      cmd_arg_r   <= 32'h0000_0000;
      resp_r      <= 40'hFF_FFFF_FFFF;
      resp_last_r <= 3'd0;
      do_read_r   <= 1'b0;
      idle_r      <= 1'b1;
      ready_r     <= 1'b0;
      acmd_cnt_r  <= 8'd0;
      app_r       <= 1'b0;
    end else begin
      cmd_valid_r <= frame_done_s;
      if (frame_done_s) begin
        cmd_index_r <= idx_s;
        cmd_arg_r   <= arg_s;
        resp_r      <= {r1_s, resp_tail_s};
        resp_last_r <= resp_last_nxt_s;
        do_read_r   <= read_nxt_s;
        idle_r      <= idle_nxt_s;
        ready_r     <= ready_nxt_s;
        acmd_cnt_r  <= acmd_nxt_s;
        app_r       <= app_nxt_s;
      end
    end
  end

  // Byte to be emitted at the next byte boundary.
  always_comb begin
    case (state_r)
      ST_RESP: begin
        case (byte_cnt_r[2:0])
          3'd0:    cur_byte_s = resp_r[39:32];
          3'd1:    cur_byte_s = resp_r[31:24];
          3'd2:    cur_byte_s = resp_r[23:16];
          3'd3:    cur_byte_s = resp_r[15:8];
          3'd4:    cur_byte_s = resp_r[7:0];
          default: cur_byte_s = 8'hFF;
        endcase
      end
      ST_TOKEN: cur_byte_s = 8'hFE;
      ST_DATA:  cur_byte_s = hold_r;
      default:  cur_byte_s = 8'hFF;
    endcase
  end

  // Sequencer next state; it advances on the falling edge that emits bit 0.
  always_comb begin
    state_nxt_s    = state_r;
    byte_cnt_nxt_s = byte_cnt_r;
    if (cs_high_s) begin
      state_nxt_s    = ST_RX;
      byte_cnt_nxt_s = 9'd0;
    end else if (frame_done_s) begin
      state_nxt_s    = ST_GAP;
      byte_cnt_nxt_s = 9'd0;
    end else if (byte_end_s) begin
      byte_cnt_nxt_s = byte_cnt_r + 9'd1;
      case (state_r)
        ST_GAP: begin
          if (byte_cnt_r == NCR_LAST_C) begin
            state_nxt_s    = ST_RESP;
            byte_cnt_nxt_s = 9'd0;
          end else begin
            state_nxt_s = ST_GAP;
          end
        end
        ST_RESP: begin
          if (byte_cnt_r == {6'd0, resp_last_r}) begin
            byte_cnt_nxt_s = 9'd0;
            if (!do_read_r) begin
              state_nxt_s = ST_RX;
            end else if (READ_GAP_BYTES == 0) begin
              state_nxt_s = ST_TOKEN;
            end else begin
              state_nxt_s = ST_RGAP;
            end
          end else begin
            state_nxt_s = ST_RESP;
          end
        end
        ST_RGAP: begin
          if (byte_cnt_r == RGAP_LAST_C) begin
            state_nxt_s    = ST_TOKEN;
            byte_cnt_nxt_s = 9'd0;
          end else begin
            state_nxt_s = ST_RGAP;
          end
        end
        ST_TOKEN: begin
          state_nxt_s    = ST_DATA;
          byte_cnt_nxt_s = 9'd0;
        end
        ST_DATA: begin
          if (byte_cnt_r == DATA_LAST_C) begin
            state_nxt_s    = ST_CRC;
            byte_cnt_nxt_s = 9'd0;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
        ST_CRC: begin
          if (byte_cnt_r == 9'd1) begin
            state_nxt_s    = ST_RX;
            byte_cnt_nxt_s = 9'd0;
          end else begin
            state_nxt_s = ST_CRC;
          end
        end
        default: begin
          state_nxt_s    = ST_RX;
          byte_cnt_nxt_s = 9'd0;
        end
      endcase
    end else begin
      state_nxt_s    = state_r;
      byte_cnt_nxt_s = byte_cnt_r;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RX;
      byte_cnt_r <= 9'd0;
    end else begin
      state_r    <= state_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
    end
  end

  // MISO shifter. The whole byte is loaded when bit 7 goes out so the data
  // holding register is free to take the next block byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_r     <= 1'b1;
      tx_bit_r   <= 3'd7;
      tx_shift_r <= 7'h7F;
    end else if (cs_high_s) begin
      miso_r   <= 1'b1;
      tx_bit_r <= 3'd7;
    end else if (frame_done_s) begin
      tx_bit_r <= 3'd7;
    end else if (sclk_fall_s) begin
      if (state_r == ST_RX) begin
        miso_r <= 1'b1;
      end else if (tx_bit_r == 3'd7) begin
        miso_r     <= cur_byte_s[7];
        tx_shift_r <= cur_byte_s[6:0];
        tx_bit_r   <= 3'd6;
      end else begin
        miso_r     <= tx_shift_r[6];
        tx_shift_r <= {tx_shift_r[5:0], 1'b1};
        tx_bit_r   <= tx_bit_r - 3'd1;
      end
    end
  end

  // Block fetch: byte 0 is requested as the token starts, byte k+1 as
  // bit 7 of byte k goes out; read data lands in hold_r one clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_r   <= 1'b0;
      mem_addr_r <= '0;
      rd_dly_r   <= 1'b0;
      hold_r     <= 8'hFF;
    end else begin
      rd_dly_r <= mem_rd_r;
      if (rd_dly_r) begin
        hold_r <= mem_rdata;
      end
      if (cs_high_s) begin
        mem_rd_r <= 1'b0;
      end else if (byte_start_s && (state_r == ST_TOKEN)) begin
        mem_rd_r   <= 1'b1;
        mem_addr_r <= base_s;
      end else if (byte_start_s && (state_r == ST_DATA) && (byte_cnt_r != DATA_LAST_C)) begin
        mem_rd_r   <= 1'b1;
        mem_addr_r <= mem_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        mem_rd_r <= 1'b0;
      end
    end
  end

  assign sd_miso    = miso_r;
  assign mem_rd     = mem_rd_r;
  assign mem_addr   = mem_addr_r;
  assign cmd_valid  = cmd_valid_r;
  assign cmd_index  = cmd_index_r;
  assign cmd_arg    = cmd_arg_r;
  assign card_ready = ready_r;

endmodule

// File: doc/sd_spi_card_responder.md
Name: sd_spi_card_responder

Overview:
Synthesizable SD-card target (SPI mode): the card end of the SD interface the host drives through sd_clk/sd_cmd/sd_d. Decodes host commands and returns R1/R7/R3 responses and single 512-byte read blocks fetched from a byte-wide memory port. Used in simulation benches and FPGA loopback builds in place of a physical card, so bootloader SD reads can be exercised end to end.

Parameters:
ADDR_W, 24, byte address width of the memory port (block number × 512 + offset, truncated to ADDR_W).
NCR_BYTES, 1, number of 0xFF bytes sent between the command's last bit and the first response byte (1..8).
READ_GAP_BYTES, 2, number of 0xFF bytes between the CMD17 R1 and the 0xFE start token (0..15).
ACMD41_BUSY, 2, number of ACMD41 commands answered 0x01 before the card reports ready (0x00).

Ports:
clk  in  1  system clock; sd_sclk period must be ≥ 8 clk periods
rst_n  in  1  asynchronous, active-low reset
sd_sclk  in  1  SPI clock from host (sd_clk), asynchronous
sd_cs_n  in  1  chip select, active low (sd_d[3])
sd_mosi  in  1  host→card data (sd_cmd)
sd_miso  out  1  card→host data (sd_d[0])
mem_rd  out  1  one-clk read strobe
mem_addr  out  ADDR_W  byte address for mem_rd
mem_rdata  in  8  read data, valid exactly 1 clk after mem_rd
cmd_valid  out  1  one-clk pulse when a 48-bit command frame is complete
cmd_index  out  6  index of last command
cmd_arg  out  32  argument of last command
card_ready  out  1  high once ACMD41 has returned 0x00

Behaviour:
- Reset: sd_miso=1, mem_rd=0, mem_addr=0, cmd_valid=0, cmd_index=0, cmd_arg=0, card_ready=0; state RX; idle flag=1; ACMD41 counter=0; app flag=0.
- sd_sclk, sd_cs_n, sd_mosi pass through 2-FF synchronizers; rising/falling edges detected in clk domain. MOSI sampled on rising edge; MISO changes on falling edge, updated ≤3 clk after the synchronized edge (SPI mode 0).
- sd_cs_n high: bit/byte counters cleared, state→RX, sd_miso=1, mem_rd=0 within 3 clk; idle flag, card_ready, ACMD41 counter preserved. Applies mid-response and mid-data.
- RX: shift MOSI; a frame starts at the first sampled 0 followed by 1 (start + transmission bits); 48 bits collected; CRC7 ignored. Frame end: latch cmd_index=bits[45:40], cmd_arg=bits[39:8], pulse cmd_valid, go to GAP (NCR_BYTES of 0xFF) then RESP. MOSI ignored outside RX.
- Responses (R1 bit0 = idle flag, bit2 = illegal command):
  CMD0 → 0x01; sets idle flag, clears card_ready and ACMD41 counter.
  CMD8 → 0x01 00 00 0X YY, X=arg[11:8], YY=arg[7:0] (R7, idle flag in R1).
  CMD55 → R1; sets app flag for next command only.
  ACMD41 (CMD41 with app flag) → 0x01 while counter < ACMD41_BUSY (counter++), else 0x00, clear idle flag, card_ready=1.
  CMD58 → R1 then OCR 0xC0FF8000 (CCS=1, block addressing).
  CMD16 → R1 (no effect; block length fixed at 512).
  CMD17 → R1; if card_ready: READ_GAP_BYTES×0xFF, token 0xFE, 512 data bytes, CRC 0xFF 0xFF, then RX. If not ready: R1=0x05, no data.
  Any other index, or CMD41 without app flag → R1 | 0x04.
- Bytes sent MSB first. After the final byte, sd_miso=1 and state→RX.
- Data fetch: byte k address = (cmd_arg×512 + k) mod 2^ADDR_W. mem_rd pulses for byte 0 on the clk that token 0xFE starts, and for byte k+1 on the falling edge that emits bit 7 of byte k; mem_rdata captured into a holding register 1 clk later. mem_addr holds its value between strobes.
- cmd_arg wrap: cmd_arg×512 computed at full 41-bit width then truncated.
- Reset asserted mid-operation: all state to reset values immediately (asynchronous).

Test Plan:
- CMD0 (40 00 00 00 00 95) after reset → cmd_valid pulse, cmd_index=0, NCR 0xFF then 0x01.
- CMD8 arg 0x000001AA → 0x01 00 00 01 AA.
- CMD55/ACMD41 repeated, ACMD41_BUSY=2 → 0x01, 0x01, 0x00; card_ready rises after third; CMD58 → 00 C0 FF 80 00.
- CMD17 arg 3 after init, memory byte = addr[7:0] → 00, FF FF, FE, bytes 00..FF twice, FF FF; mem_addr 0x600..0x7FF, 512 mem_rd pulses.
- CMD17 before init → 0x05, no token, no mem_rd; CMD5 in idle → 0x05.
- sd_cs_n high at data byte 100 → sd_miso=1 within 3 clk; after CS low, CMD17 arg 0 restarts cleanly at mem_addr 0. rst_n low mid-block → card_ready=0, sd_miso=1.
